// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEMWAIT = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load sitting in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_wr,
  input  logic       ex_mem_rd,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is never really written, so a load targeting it cannot create a hazard.
  assign load_use = ex_mem_rd && ex_reg_wr && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule : hazard_detect

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use stalls,
// wrong-path squash on redirect, memory-wait freeze with timeout, perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_useRs1,
  input  logic             id_useRs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regWR,
  input  logic             ex_memRd,
  input  logic             ex_doBranch,
  input  logic             ex_doJump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pcStall,
  output logic             ifidStall,
  output logic             idexStall,
  output logic             exmemStall,
  output logic             memwbBubble,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             memErr,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int              WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              mem_err;

  logic load_use;
  logic freeze;
  logic redirect;
  logic lu_stall;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_useRs1),
    .id_use_rs2 (id_useRs2),
    .ex_rd      (ex_rd),
    .ex_reg_wr  (ex_regWR),
    .ex_mem_rd  (ex_memRd),
    .load_use   (load_use)
  );

  // Qualified with rst_n so every control output drops the instant reset asserts,
  // even while mem_req is still high from the interrupted access.
  assign freeze   = rst_n && ((state == ST_ERR) || (mem_req && !mem_ready));
  assign redirect = rst_n && (ex_doBranch || ex_doJump) && !freeze;
  assign lu_stall = rst_n && load_use && !freeze && !redirect;

  assign pcStall     = freeze || lu_stall;
  assign ifidStall   = freeze || lu_stall;
  assign idexStall   = freeze;
  assign exmemStall  = freeze;
  assign memwbBubble = freeze;
  assign ifidFlush   = redirect;
  assign idexFlush   = redirect || lu_stall;
  assign memErr      = mem_err;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_nxt    = ST_MEMWAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEMWAIT: begin
        // A dropped request is treated like a completed access.
        if (!mem_req || mem_ready) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_nxt = ST_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ST_ERR: state_nxt = ST_ERR;
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ST_ERR) mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (pcStall && (stallCycles != '1)) stallCycles <= stallCycles + 1'b1;
      if (redirect && (flushCount != '1)) flushCount <= flushCount + 1'b1;
    end
  end

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: two configurations of pipeline_ctrl driven in parallel,
// checked every cycle against a rule-level model plus directed literal checks.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_useRs1, id_useRs2, ex_regWR, ex_memRd;
  logic       ex_doBranch, ex_doJump, mem_req, mem_ready;

  logic [7:0] flags_a, flags_b;
  logic [1:0] stall_a, flush_a;
  logic [7:0] stall_b, flush_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_rd(ex_rd), .ex_regWR(ex_regWR), .ex_memRd(ex_memRd),
    .ex_doBranch(ex_doBranch), .ex_doJump(ex_doJump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pcStall(flags_a[7]), .ifidStall(flags_a[6]), .idexStall(flags_a[5]),
    .exmemStall(flags_a[4]), .memwbBubble(flags_a[3]), .ifidFlush(flags_a[2]),
    .idexFlush(flags_a[1]), .memErr(flags_a[0]),
    .stallCycles(stall_a), .flushCount(flush_a)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(6), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_rd(ex_rd), .ex_regWR(ex_regWR), .ex_memRd(ex_memRd),
    .ex_doBranch(ex_doBranch), .ex_doJump(ex_doJump),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pcStall(flags_b[7]), .ifidStall(flags_b[6]), .idexStall(flags_b[5]),
    .exmemStall(flags_b[4]), .memwbBubble(flags_b[3]), .ifidFlush(flags_b[2]),
    .idexFlush(flags_b[1]), .memErr(flags_b[0]),
    .stallCycles(stall_b), .flushCount(flush_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flag order: pcStall ifidStall idexStall exmemStall memwbBubble ifidFlush idexFlush memErr
  int unsigned m_timeout [2] = '{4, 6};
  int unsigned m_max     [2] = '{3, 255};
  bit          m_err     [2];
  int unsigned m_streak  [2];
  int unsigned m_stall   [2];
  int unsigned m_flush   [2];

  function automatic bit hazard();
    bit hit1 = id_useRs1 && (id_rs1 == ex_rd);
    bit hit2 = id_useRs2 && (id_rs2 == ex_rd);
    return ex_memRd && ex_regWR && (ex_rd != 5'd0) && (hit1 || hit2);
  endfunction

  function automatic logic [7:0] expected_flags(input bit err);
    bit frz  = err || (mem_req && !mem_ready);
    bit redir = (ex_doBranch || ex_doJump) && !frz;
    bit lu   = hazard() && !frz && !redir;
    return {frz || lu, frz || lu, frz, frz, frz, redir, redir || lu, err};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0]  exp_f;
      logic [7:0]  got_f;
      logic [31:0] got_s;
      logic [31:0] got_c;
      got_f = (i == 0) ? flags_a : flags_b;
      got_s = (i == 0) ? 32'(stall_a) : 32'(stall_b);
      got_c = (i == 0) ? 32'(flush_a) : 32'(flush_b);
      if (!rst_n) begin
        m_err[i] = 1'b0; m_streak[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        check($sformatf("model_reset_flags[%0d]", i), 32'(got_f), 32'h0);
        check($sformatf("model_reset_cnt[%0d]", i), got_s | got_c, 32'h0);
      end else begin
        exp_f = expected_flags(m_err[i]);
        check($sformatf("model_flags[%0d]", i), 32'(got_f), 32'(exp_f));
        check($sformatf("model_stallCycles[%0d]", i), got_s, m_stall[i]);
        check($sformatf("model_flushCount[%0d]", i), got_c, m_flush[i]);
        if (exp_f[7] && m_stall[i] < m_max[i]) m_stall[i]++;
        if (exp_f[2] && m_flush[i] < m_max[i]) m_flush[i]++;
        // ERR once the pipe has been frozen by one access for the entry cycle
        // plus MEM_TIMEOUT wait cycles.
        if (!m_err[i]) begin
          if (mem_req && !mem_ready) begin
            m_streak[i]++;
            if (m_streak[i] == m_timeout[i] + 1) m_err[i] = 1'b1;
          end else begin
            m_streak[i] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_useRs1 = 1'b0; id_useRs2 = 1'b0;
    ex_rd = 5'd0; ex_regWR = 1'b0; ex_memRd = 1'b0;
    ex_doBranch = 1'b0; ex_doJump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_in(input logic [4:0] rd);
    ex_memRd = 1'b1; ex_regWR = 1'b1; ex_rd = rd; id_rs1 = rd; id_useRs1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick(); tick();
    check("reset_flags", 32'(flags_a), 32'h0);
    check("reset_counters", 32'(stall_b) + 32'(flush_b), 32'h0);
    rst_n = 1'b1;

    // Load-use on x5: one-cycle stall of PC and IF/ID plus ID/EX bubble.
    load_use_in(5'd5);
    #1 check("load_use_flags", 32'(flags_a), 32'hC2);
    tick(); idle();
    #1 check("load_use_stallCycles", 32'(stall_b), 32'd1);
    check("load_use_released", 32'(flags_a), 32'h00);

    // Load to x0 is not a hazard.
    load_use_in(5'd0);
    #1 check("x0_load_flags", 32'(flags_a), 32'h00);
    tick(); idle();

    // Branch wins over load-use.
    load_use_in(5'd7); ex_doBranch = 1'b1;
    #1 check("branch_lu_flags", 32'(flags_a), 32'h06);
    tick(); idle();
    #1 check("branch_lu_flushCount", 32'(flush_b), 32'd1);
    check("branch_lu_stallCycles", 32'(stall_b), 32'd1);

    // Memory wait for 3 cycles with a jump held in EX; the redirect lands in the ready cycle.
    mem_req = 1'b1; ex_doJump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("memwait_freeze_%0d", i), 32'(flags_a), 32'hF8);
      tick();
    end
    mem_ready = 1'b1;
    #1 check("memwait_ready_redirect", 32'(flags_a), 32'h06);
    tick(); idle();
    #1 check("memwait_flushCount", 32'(flush_b), 32'd2);
    check("memwait_stallCycles", 32'(stall_b), 32'd4);

    // Timeout on the MEM_TIMEOUT=4 instance: entry cycle + 4 wait cycles, then ERR.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("timeout_pre_err_%0d", i), 32'(flags_a), 32'hF8);
      tick();
    end
    #1 check("timeout_err", 32'(flags_a), 32'hF9);
    idle();
    #1 check("err_freeze_held", 32'(flags_a), 32'hF9);
    tick();
    #1 check("err_sticky", 32'(flags_a), 32'hF9);
    check("err_stall_saturated", 32'(stall_a), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("err_cleared_by_reset", 32'(flags_a), 32'h00);

    // Saturation on the 2-bit counter after 5 stall cycles.
    load_use_in(5'd9);
    repeat (5) tick();
    idle();
    #1 check("sat_stallCycles_a", 32'(stall_a), 32'd3);
    check("sat_stallCycles_b", 32'(stall_b), 32'd5);

    // Reset asserted mid-MEMWAIT with the request still high.
    mem_req = 1'b1;
    tick(); tick();
    #1 check("pre_reset_freeze", 32'(flags_b), 32'hF8);
    rst_n = 1'b0;
    #1 check("async_reset_flags_a", 32'(flags_a), 32'h00);
    check("async_reset_flags_b", 32'(flags_b), 32'h00);
    check("async_reset_counters", 32'(stall_a) + 32'(stall_b) + 32'(flush_b), 32'h0);
    tick();
    rst_n = 1'b1; idle();

    // Randomized traffic with small register indices so hazards occur often.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit slow = ((cyc / 250) % 2) == 1;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_useRs1   = 1'($urandom_range(0, 1));
      id_useRs2   = 1'($urandom_range(0, 1));
      ex_regWR    = ($urandom_range(0, 3) != 0);
      ex_memRd    = ($urandom_range(0, 1) == 1);
      ex_doBranch = ($urandom_range(0, 5) == 0);
      ex_doJump   = ($urandom_range(0, 9) == 0);
      mem_req     = ($urandom_range(0, 2) != 0);
      mem_ready   = slow ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
      rst_n       = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1; idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_ctrl
